fpa_result_scoreboard: RTL and testbench
========================================

// Module: fpa_result_scoreboard
// PURPOSE
//  Response side of the pipeFPA64 self-check: receives the adder's result stream and compares it in order against an expected-value queue.
//  The stimulus side fills the queue. Results are checked only when the adder marks them valid.
//  Ends in a sticky done/correct verdict after NUM_VECTORS checks.
// PARAMETERS
//  WIDTH        64  operand/result width (IEEE-754 double)
//  DEPTH        8   expected-queue entries; power of 2, >=2
//  NUM_VECTORS  8   number of checks that complete a run; 1..255
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  exp_valid    in   1      expected value offered by stimulus side
//  exp_data     in   WIDTH  expected result
//  exp_ready    out  1      queue can accept exp_data this cycle
//  res_valid    in   1      adder result valid this cycle
//  res_data     in   WIDTH  adder result
//  check_count  out  8      results checked so far
//  err_count    out  8      mismatches + orphans; saturates at 255
//  first_exp    out  WIDTH  expected value of first mismatch (0 if none)
//  first_got    out  WIDTH  received value of first mismatch (0 if none)
//  orphan       out  1      sticky: result arrived with empty queue
//  done         out  1      sticky: run complete
//  correct      out  1      done & err_count==0 & ~orphan (combinational)
// BEHAVIOUR
//  Reset: pointers, occupancy, counts, first_*, orphan, done all 0; state RUN; exp_ready=1 in the next cycle.
//  Reset asserted mid-run discards queue contents and verdict, with no exception.
//  Push: exp_valid & exp_ready. exp_ready = (state==RUN) & ~full.
//  exp_ready is based on occupancy before this edge, so a same-cycle pop never frees a slot for a push while full.
//  Check: res_valid & state==RUN.
//   - Queue non-empty: pop head, compare with res_data at that same edge.
//     Mismatch increments err_count. The first mismatch latches first_exp/first_got.
//   - Queue empty: set orphan, increment err_count. The push of that cycle still proceeds; there is no bypass.
//   - Either case: check_count += 1.
//  Simultaneous push and pop when non-full: occupancy unchanged, both succeed.
//  Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
//  Latency: counts/flags update at the edge where res_valid is sampled, visible the next cycle.
//  No combinational path from res_* to outputs except via correct.
//  FSM: RUN -> DONE at the edge where the check making check_count==NUM_VECTORS occurs.
//   DONE is absorbing until rst. done=1, exp_ready=0, res_valid ignored, all counts frozen.
//  err_count holds at 255 once reached; further errors still block correct.
// CONFIGURATION
//  FPA_ZERO_EQ_EN defined: +0 (0x0000...) and -0 (0x8000...) compare equal; all other values are bit-exact.
//  Undefined: all comparisons are bit-exact, so -0 vs +0 counts as a mismatch.
// STRUCTURE
//  fpa_tb_pkg: WIDTH constant, SIGN_MASK 64'h8000_0000_0000_0000, sb_state_t {RUN, DONE}, fp_eq() compare function.
//  fp_eq() honours FPA_ZERO_EQ_EN.
//  Sub-module fpa_exp_fifo: sync FIFO (WIDTH, DEPTH) with push/pop/full/empty/head, no output register.
//  The scoreboard holds the FSM, counters and first-mismatch capture.
// TESTING
//  1 Push 90+90 exp 0x4066800000000000 x8; feed the same 8 results, one per cycle from cycle 3.
//    -> done at the 8th check edge; correct=1; err_count=0.
//  2 Same run, but result 4 = 0x4051800000000000.
//    -> err_count=1; first_exp=0x4066800000000000; first_got=0x4051800000000000; correct=0.
//  3 res_valid with empty queue at cycle 1 -> orphan=1, err_count=1, check_count=1; correct=0 at done.
//  4 Push 8 entries with no results -> exp_ready=0 after the 8th push.
//    Push+res same cycle while full: no push accepted, occupancy drops to 7.
//  5 Expected 0x0000000000000000, result 0x8000000000000000.
//    -> mismatch without FPA_ZERO_EQ_EN; match with it defined.
//  6 rst pulsed after 3 checks with 1 error -> all counts 0, queue empty; a clean 8-vector rerun gives correct=1.

Source files
------------

// File: rtl/fpa_tb_pkg.sv
// Shared types and the result-compare rule for the pipeFPA64 response scoreboard.
// Build option: FPA_ZERO_EQ_EN makes +0 and -0 compare equal.
package fpa_tb_pkg;

    localparam int unsigned WIDTH = 64;
    localparam logic [WIDTH-1:0] SIGN_MASK = 64'h8000_0000_0000_0000;

`ifdef FPA_ZERO_EQ_EN
    localparam bit ZERO_EQ_EN = 1'b1;
`else
    localparam bit ZERO_EQ_EN = 1'b0;
`endif

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } sb_state_t;

    // Bit-exact equality, optionally folding the two signed zeros together
    function automatic logic fp_eq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic both_zero;
        both_zero = (((a | b) & ~SIGN_MASK) == '0);
        return (a == b) || (ZERO_EQ_EN && both_zero);
    endfunction

endpackage

// File: rtl/fpa_exp_fifo.sv
// Synchronous expected-value FIFO; head is read straight from storage (no output register).
module fpa_exp_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpa_result_scoreboard.sv
// In-order checker of adder results against an expected queue, ending in a sticky verdict.
// Build option: FPA_ZERO_EQ_EN (signed-zero equality, see fpa_tb_pkg::fp_eq).
module fpa_result_scoreboard
    import fpa_tb_pkg::*;
#(
    parameter int unsigned WIDTH       = fpa_tb_pkg::WIDTH,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NUM_VECTORS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_ready,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic [7:0]       check_count,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic             orphan,
    output logic             done,
    output logic             correct
);

    localparam int unsigned CNT_W = 8;

    sb_state_t        state;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             check;
    logic             mismatch;
    logic             miss;
    logic             err_hit;
    logic             mm_seen;

    // Readiness uses pre-edge occupancy: a pop in the same cycle never frees a full queue
    assign exp_ready = (state == RUN) & ~full;
    assign push      = exp_valid & exp_ready;
    assign check     = res_valid & (state == RUN);
    assign pop       = check & ~empty;
    assign miss      = check & empty;
    assign mismatch  = pop & ~fp_eq(64'(head), 64'(res_data));
    assign err_hit   = mismatch | miss;

    fpa_exp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (exp_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            check_count <= '0;
            err_count   <= '0;
            first_exp   <= '0;
            first_got   <= '0;
            orphan      <= 1'b0;
            mm_seen     <= 1'b0;
        end else if (check) begin
            check_count <= check_count + CNT_W'(1);
            if (check_count == CNT_W'(NUM_VECTORS - 1)) state <= DONE;
            if (err_hit && (err_count != {CNT_W{1'b1}})) err_count <= err_count + CNT_W'(1);
            if (miss) orphan <= 1'b1;
            // Only the first data mismatch is kept; orphans do not latch first_*
            if (mismatch && !mm_seen) begin
                mm_seen   <= 1'b1;
                first_exp <= head;
                first_got <= res_data;
            end
        end
    end

    assign done    = (state == DONE);
    assign correct = done & (err_count == '0) & ~orphan;

endmodule

// File: tb/tb_fpa_result_scoreboard.sv
// Table-driven bench for fpa_result_scoreboard with a queue-based reference model.
module tb_fpa_result_scoreboard;

    localparam int unsigned W     = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NV    = 8;
    localparam logic [63:0] ZP    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ZN    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] V180  = 64'h4066_8000_0000_0000;
    localparam logic [63:0] V70   = 64'h4051_8000_0000_0000;
    localparam logic [63:0] V1    = 64'h3FF0_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_ready;
    logic         res_valid = 1'b0;
    logic [W-1:0] res_data = '0;
    logic [7:0]   check_count;
    logic [7:0]   err_count;
    logic [W-1:0] first_exp;
    logic [W-1:0] first_got;
    logic         orphan;
    logic         done;
    logic         correct;

    fpa_result_scoreboard #(.WIDTH(W), .DEPTH(DEPTH), .NUM_VECTORS(NV)) dut (
        .clk         (clk),
        .rst         (rst),
        .exp_valid   (exp_valid),
        .exp_data    (exp_data),
        .exp_ready   (exp_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .check_count (check_count),
        .err_count   (err_count),
        .first_exp   (first_exp),
        .first_got   (first_got),
        .orphan      (orphan),
        .done        (done),
        .correct     (correct)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0] mq[$];
    int          m_chk;
    int          m_err;
    bit          m_orphan;
    bit          m_run;
    bit          m_seen;
    logic [63:0] m_fe;
    logic [63:0] m_fg;

    typedef struct {
        string       name;
        logic [31:0] exp_mask;
        logic [31:0] res_mask;
        logic [63:0] exp_val;
        int          bad_idx;
        logic [63:0] bad_val;
        int          chk;
        int          err;
        bit          orph;
        bit          corr;
        logic [63:0] fe;
        logic [63:0] fg;
    } vec_t;

    vec_t vecs[5];

    function automatic bit ref_eq(input logic [63:0] a, input logic [63:0] b);
        if (a == b) return 1'b1;
`ifdef FPA_ZERO_EQ_EN
        if ((a == ZP || a == ZN) && (b == ZP || b == ZN)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] junk();
        return {$urandom(), $urandom()};
    endfunction

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic model_edge(input bit r, input bit ev, input logic [63:0] ed,
                              input bit rv, input logic [63:0] rd);
        bit          ready;
        logic [63:0] e;
        if (r) begin
            mq.delete();
            m_chk = 0; m_err = 0; m_orphan = 0; m_run = 1; m_seen = 0;
            m_fe = '0; m_fg = '0;
            return;
        end
        ready = m_run && (mq.size() < DEPTH);
        if (rv && m_run) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (!ref_eq(e, rd)) begin
                    if (m_err < 255) m_err++;
                    if (!m_seen) begin
                        m_seen = 1; m_fe = e; m_fg = rd;
                    end
                end
            end else begin
                m_orphan = 1;
                if (m_err < 255) m_err++;
            end
            m_chk++;
            if (m_chk == NV) m_run = 0;
        end
        if (ev && ready) mq.push_back(ed);
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".exp_ready"},   64'(exp_ready),   64'(m_run && (mq.size() < DEPTH)));
        cmp({tag, ".check_count"}, 64'(check_count), 64'(m_chk));
        cmp({tag, ".err_count"},   64'(err_count),   64'(m_err));
        cmp({tag, ".orphan"},      64'(orphan),      64'(m_orphan));
        cmp({tag, ".done"},        64'(done),        64'(!m_run));
        cmp({tag, ".correct"},     64'(correct),     64'(!m_run && m_err == 0 && !m_orphan));
        cmp({tag, ".first_exp"},   first_exp,        m_fe);
        cmp({tag, ".first_got"},   first_got,        m_fg);
    endtask

    task automatic step(input string tag, input bit r, input bit ev, input logic [63:0] ed,
                        input bit rv, input logic [63:0] rd);
        @(negedge clk);
        rst       = r;
        exp_valid = ev;
        exp_data  = ev ? ed : junk();
        res_valid = rv;
        res_data  = rv ? rd : junk();
        @(posedge clk);
        model_edge(r, ev, exp_data, rv, res_data);
        #1;
        check_all(tag);
    endtask

    task automatic run_vector(input int idx, input bit do_rst);
        vec_t        v;
        int          ridx;
        logic [63:0] rval;
        bit          rv;
        v = vecs[idx];
        if (do_rst) step({v.name, ".reset"}, 1'b1, 1'b0, '0, 1'b0, '0);
        ridx = 0;
        for (int c = 0; c < 16; c++) begin
            rv   = v.res_mask[c];
            rval = (rv && ridx == v.bad_idx) ? v.bad_val : v.exp_val;
            step(v.name, 1'b0, v.exp_mask[c], v.exp_val, rv, rval);
            if (rv) ridx++;
        end
        cmp({v.name, ".final_done"},    64'(done),        64'd1);
        cmp({v.name, ".final_chk"},     64'(check_count), 64'(v.chk));
        cmp({v.name, ".final_err"},     64'(err_count),   64'(v.err));
        cmp({v.name, ".final_orphan"},  64'(orphan),      64'(v.orph));
        cmp({v.name, ".final_correct"}, 64'(correct),     64'(v.corr));
        cmp({v.name, ".final_fexp"},    first_exp,        v.fe);
        cmp({v.name, ".final_fgot"},    first_got,        v.fg);
    endtask

    initial begin
        vecs[0] = '{"clean",   32'h0FF, 32'h7F8, V180, -1, '0,   8, 0, 1'b0, 1'b1, '0,   '0};
        vecs[1] = '{"bad4",    32'h0FF, 32'h7F8, V180,  3, V70,  8, 1, 1'b0, 1'b0, V180, V70};
        vecs[2] = '{"orphan",  32'h1FC, 32'h7F2, V180, -1, '0,   8, 1, 1'b1, 1'b0, '0,   '0};
        vecs[3] = '{"overrun", 32'h3FF, 32'hFFC, V180, -1, '0,   8, 0, 1'b0, 1'b1, '0,   '0};
`ifdef FPA_ZERO_EQ_EN
        vecs[4] = '{"zero",    32'h0FF, 32'h7F8, ZP,    0, ZN,   8, 0, 1'b0, 1'b1, '0,   '0};
`else
        vecs[4] = '{"zero",    32'h0FF, 32'h7F8, ZP,    0, ZN,   8, 1, 1'b0, 1'b0, ZP,   ZN};
`endif
        model_edge(1'b1, 1'b0, '0, 1'b0, '0);

        for (int i = 0; i < 5; i++) run_vector(i, 1'b1);

        // Full queue: a same-cycle push is refused, the pop still happens
        step("full.reset", 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step("full.fill", 1'b0, 1'b1, 64'(i + 1), 1'b0, '0);
        cmp("full.ready_low", 64'(exp_ready), 64'd0);
        step("full.pushpop", 1'b0, 1'b1, 64'd99, 1'b1, 64'd1);
        cmp("full.ready_back", 64'(exp_ready), 64'd1);
        for (int i = 2; i <= 8; i++) step("full.drain", 1'b0, 1'b0, '0, 1'b1, 64'(i));
        cmp("full.done",    64'(done),      64'd1);
        cmp("full.err",     64'(err_count), 64'd0);
        cmp("full.correct", 64'(correct),   64'd1);

        // Mid-run reset discards the queue and the partial verdict
        step("mid.reset", 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step("mid.run", 1'b0, 1'b1, V1, i >= 2, (i == 3) ? V70 : V1);
        end
        cmp("mid.chk_before", 64'(check_count), 64'd3);
        cmp("mid.err_before", 64'(err_count),   64'd1);
        step("mid.pulse", 1'b1, 1'b1, V1, 1'b0, '0);
        cmp("mid.chk_after",  64'(check_count), 64'd0);
        cmp("mid.err_after",  64'(err_count),   64'd0);
        cmp("mid.fexp_after", first_exp,        64'd0);
        run_vector(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
